// File: rtl/pwm_peripheral_if.sv
// Control/status bundle between the SPI register file and the PWM peripheral.
// master: register file side (drives enables and duty, observes pin drive).
// slave:  PWM peripheral side.
interface pwm_peripheral_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic [7:0]  duty_active;
    logic        period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  duty_active,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output duty_active,
        output period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-pin PWM peripheral: each pin is forced low, held high or driven by a
// shared PWM waveform. Period is 2^PWM_BITS steps of CLK_DIV clk each.
// Optional build macro PWM_SYNC_UPDATE_EN: duty_active reloads only at the
// period boundary (plus once after reset) so a period is never truncated.
// Without it duty_active follows pwm_duty_cycle with one clk of latency.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV  = 13,
    parameter int unsigned PWM_BITS = 8
) (
    input logic            clk,
    input logic            rst_n,
    pwm_peripheral_if.slave bus
);

    localparam logic [15:0]         DivMax = 16'(CLK_DIV - 1);
    localparam logic [PWM_BITS-1:0] PwmMax = {PWM_BITS{1'b1}};

    logic [15:0]         div_cnt_q, div_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0]          duty_active_q, duty_active_d;
    logic [15:0]         out_q, out_d;
    logic                period_start_q, period_start_d;
    logic                step, wrap, pwm_sig;
    logic [15:0]         en_out, en_pwm;

    assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // Clock divider and period counter next-state; wrap marks the last clk of a period.
    always_comb begin
        step           = (div_cnt_q == DivMax);
        div_cnt_d      = step ? 16'd0 : div_cnt_q + 16'd1;
        pwm_cnt_d      = step ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        wrap           = step && (pwm_cnt_q == PwmMax);
        period_start_d = wrap;
    end

    // Comparator: full scale is a true 100%, not 255/256.
    always_comb begin
        pwm_sig = 1'b0;
        if (duty_active_q == 8'hFF) begin
            pwm_sig = 1'b1;
        end else begin
            pwm_sig = (pwm_cnt_q < duty_active_q);
        end
    end

    // Per-pin mux: disabled -> 0, static -> 1, PWM mode -> pwm_sig.
    always_comb begin
        out_d = (en_out & ~en_pwm) | (en_out & en_pwm & {16{pwm_sig}});
    end

`ifdef PWM_SYNC_UPDATE_EN
    logic loaded_q;

    // Duty reloads at the period boundary, and once right after reset release.
    always_comb begin
        duty_active_d = duty_active_q;
        if (wrap || !loaded_q) begin
            duty_active_d = bus.pwm_duty_cycle;
        end
    end

    // Tracks whether the post-reset duty load has happened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded_q <= 1'b0;
        end else begin
            loaded_q <= 1'b1;
        end
    end
`else
    // Duty follows the register every clk.
    always_comb begin
        duty_active_d = bus.pwm_duty_cycle;
    end
`endif

    // State and output registers; reset clears pins asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q      <= 16'd0;
            pwm_cnt_q      <= '0;
            duty_active_q  <= 8'h00;
            out_q          <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_active_q  <= duty_active_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign bus.out          = out_q;
    assign bus.duty_active  = duty_active_q;
    assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral with CLK_DIV = 2 (512 clk period).
// The reference model works from elapsed time since reset release: the
// position in the period and the duty value decide each pin.
module tb_pwm_peripheral;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned P       = 256 * CLK_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pwm_peripheral_if bus ();

    pwm_peripheral #(
        .CLK_DIV  (CLK_DIV),
        .PWM_BITS (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] out;
        logic [7:0]  duty;
        logic        ps;
        int unsigned k;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned k        = 0;   // clk edges since reset release
    logic [7:0]  dm       = 8'h00; // model of duty currently in use

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endfunction

    // Apply inputs for the next edge and queue the response expected after it.
    task automatic drive(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        int unsigned phase;
        logic        sig;
        exp_t        e;
        bus.en_reg_out_7_0  = eo[7:0];
        bus.en_reg_out_15_8 = eo[15:8];
        bus.en_reg_pwm_7_0  = ep[7:0];
        bus.en_reg_pwm_15_8 = ep[15:8];
        bus.pwm_duty_cycle  = d;
        k     = k + 1;
        phase = (k - 1) % P;
        sig   = (dm == 8'hFF) || (phase < 32'(dm) * CLK_DIV);
        e.out = (eo & ~ep) | (eo & ep & {16{sig}});
        e.ps  = (k % P == 0);
`ifdef PWM_SYNC_UPDATE_EN
        if (k == 1 || k % P == 0) dm = d;
`else
        dm = d;
`endif
        e.duty = dm;
        e.k    = k;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare every presented output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("out@k%0d", e.k), 32'(bus.out), 32'(e.out));
                check($sformatf("duty@k%0d", e.k), 32'(bus.duty_active), 32'(e.duty));
                check($sformatf("ps@k%0d", e.k), 32'(bus.period_start), 32'(e.ps));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int         n;
        logic [7:0] dv [4];
        logic [15:0] reo, rep;
        logic [7:0]  rd;

        // Reset held with enables asserted: pins must stay low.
        bus.en_reg_out_7_0  = 8'hFF;
        bus.en_reg_out_15_8 = 8'hFF;
        bus.en_reg_pwm_7_0  = 8'h00;
        bus.en_reg_pwm_15_8 = 8'h00;
        bus.pwm_duty_cycle  = 8'h80;
        repeat (3) @(negedge clk);
        check("rst_out", 32'(bus.out), 32'h0);
        check("rst_duty", 32'(bus.duty_active), 32'h0);
        check("rst_ps", 32'(bus.period_start), 32'h0);

        rst_n = 1'b1;
        k     = 0;
        dm    = 8'h00;

        // All zero for two periods; count period_start pulses.
        n = 0;
        for (int i = 0; i < 2 * int'(P); i++) begin
            drive(16'h0000, 16'h0000, 8'h00);
            n += int'(bus.period_start);
        end
        check("ps_count_2p", 32'(n), 32'd2);

        // Static high on all pins, duty irrelevant.
        drive(16'hFFFF, 16'h0000, 8'h00);
        check("static_ffff", 32'(bus.out), 32'hFFFF);
        repeat (20) drive(16'hFFFF, 16'h0000, 8'h00);
        repeat (20) drive(16'hFFFF, 16'h0000, 8'h80);

        // Pin 0 at 50%, pins 7..1 static, upper byte off.
        do drive(16'h00FF, 16'h0001, 8'h80); while (k % P != 0);
        n = 0;
        for (int i = 0; i < int'(P); i++) begin
            drive(16'h00FF, 16'h0001, 8'h80);
            n += int'(bus.out[0]);
        end
        check("pin0_high_50", 32'(n), 32'd256);

        // Duty boundaries on pin 15.
        dv[0] = 8'h00; dv[1] = 8'hFF; dv[2] = 8'h01; dv[3] = 8'hFE;
        foreach (dv[j]) begin
            do drive(16'h8000, 16'h8000, dv[j]); while (k % P != 0);
            n = 0;
            for (int i = 0; i < int'(P); i++) begin
                drive(16'h8000, 16'h8000, dv[j]);
                n += int'(bus.out[15]);
            end
            check($sformatf("pin15_high_d%02h", dv[j]), 32'(n),
                  (dv[j] == 8'hFF) ? P : 32'(dv[j]) * CLK_DIV);
        end

        // Duty 0x40 -> 0xC0 in the middle of a period.
        do drive(16'h8000, 16'h8000, 8'h40); while (k % P != 0);
        n = 0;
        for (int i = 0; i < int'(P); i++) begin
            drive(16'h8000, 16'h8000, (i < 256) ? 8'h40 : 8'hC0);
            n += int'(bus.out[15]);
        end
`ifdef PWM_SYNC_UPDATE_EN
        check("chg_cur_period", 32'(n), 32'd128);
`else
        check("chg_cur_period", 32'(n), 32'd255);
`endif
        n = 0;
        for (int i = 0; i < int'(P); i++) begin
            drive(16'h8000, 16'h8000, 8'hC0);
            n += int'(bus.out[15]);
        end
        check("chg_next_period", 32'(n), 32'd384);

        // Randomised enables and duty.
        reo = 16'h0000; rep = 16'h0000; rd = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                reo = 16'($urandom);
                rep = 16'($urandom);
            end
            if ($urandom_range(0, 63) == 0) begin
                rd = 8'($urandom);
                if ($urandom_range(0, 3) == 0) rd = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            end
            drive(reo, rep, rd);
        end

        // Asynchronous reset while pin 0 is high.
        do drive(16'h0001, 16'h0001, 8'h80); while (k % P != 0);
        repeat (100) drive(16'h0001, 16'h0001, 8'h80);
        check("pre_rst_pin0", 32'(bus.out[0]), 32'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(bus.out), 32'h0);
        check("async_rst_duty", 32'(bus.duty_active), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        dm    = 8'h00;
        n     = 0;
        for (int i = 0; i < int'(P) + 20; i++) begin
            drive(16'h0001, 16'h0001, 8'h80);
            if (bus.period_start) n += int'(k);
        end
        check("ps_after_rerst", 32'(n), P);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
